// File: rtl/pingpong_dsp_stage.sv
// pingpong_dsp_stage
// Drains one full frame from the MOSI ping-pong RAM read port and applies
// out = min(max, ((in * gain) >> SHIFT) + offset) to every byte. Each result is
// written into the free MISO bank. Both banks are then released with a
// simultaneous one-cycle finish pulse.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   readyb_in       input bank full            (sampled in IDLE only)
//   addrb_in        input RAM read address
//   doutb_in        input RAM read data, one cycle after address
//   finishb_in      pulse: input bank consumed
//   readya_out      output bank free           (sampled in IDLE only)
//   addra_out       output RAM write address
//   dina_out        output RAM write data
//   wea_out         output RAM write enable
//   finisha_out     pulse: output bank written
//   gain, offset    arithmetic coefficients, latched at frame start
//   busy            high whenever not idle
//   frame_cnt       completed frames, wrapping
module pingpong_dsp_stage #(
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned FRAME_LEN = 128,
  parameter int unsigned SHIFT     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              readyb_in,
  output logic [ADDR_W-1:0] addrb_in,
  input  logic [DATA_W-1:0] doutb_in,
  output logic              finishb_in,
  input  logic              readya_out,
  output logic [ADDR_W-1:0] addra_out,
  output logic [DATA_W-1:0] dina_out,
  output logic              wea_out,
  output logic              finisha_out,
  input  logic [7:0]        gain,
  input  logic [7:0]        offset,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FRAME_LEN - 1);
  localparam int unsigned       ProdW    = DATA_W + 8;

  typedef enum logic [2:0] {StIdle, StRead, StDrain, StDone, StSettle} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [7:0]          gain_q, gain_d;
  logic [7:0]          offset_q, offset_d;
  logic                s1_valid_q;
  logic [ADDR_W-1:0]   s1_addr_q;
  logic                wea_q;
  logic [ADDR_W-1:0]   addra_q;
  logic [DATA_W-1:0]   dina_q;
  logic [15:0]         frame_cnt_q, frame_cnt_d;

  logic                start;
  logic [ProdW-1:0]    prod, prod_shr;
  logic [DATA_W-1:0]   prod_sat;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   result;

  assign start = (state_q == StIdle) && readyb_in && readya_out;

  // Clamp the shifted product first so the offset add fits in DATA_W+1 bits.
  // min(max, min(max, p) + o) equals min(max, p + o), so no overflow can leak.
  always_comb begin
    prod     = {{8{1'b0}}, doutb_in} * {{DATA_W{1'b0}}, gain_q};
    prod_shr = prod >> SHIFT;
    prod_sat = (|prod_shr[ProdW-1:DATA_W]) ? '1 : prod_shr[DATA_W-1:0];
    sum      = {1'b0, prod_sat} + (DATA_W + 1)'(offset_q);
    result   = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = (state_q == StRead) ? rd_addr_q + 1'b1 : '0;
    gain_d      = gain_q;
    offset_d    = offset_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRead;
          gain_d   = gain;
          offset_d = offset;
        end
      end
      StRead: begin
        if (rd_addr_q == LastAddr) state_d = StDrain;
      end
      // Leave once the final write is on the output port.
      StDrain: begin
        if (wea_q && (addra_q == LastAddr)) state_d = StDone;
      end
      StDone: begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = StSettle;
      end
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rd_addr_q   <= '0;
      gain_q      <= '0;
      offset_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      wea_q       <= 1'b0;
      addra_q     <= '0;
      dina_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      gain_q      <= gain_d;
      offset_q    <= offset_d;
      // Stage 1 tracks the address whose data arrives on doutb_in next cycle.
      s1_valid_q  <= (state_q == StRead);
      s1_addr_q   <= rd_addr_q;
      wea_q       <= s1_valid_q;
      addra_q     <= s1_valid_q ? s1_addr_q : '0;
      dina_q      <= s1_valid_q ? result : '0;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign addrb_in    = (state_q == StRead) ? rd_addr_q : '0;
  assign addra_out   = addra_q;
  assign dina_out    = dina_q;
  assign wea_out     = wea_q;
  assign finishb_in  = (state_q == StDone);
  assign finisha_out = (state_q == StDone);
  assign busy        = (state_q != StIdle);
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_pingpong_dsp_stage.sv
// Scoreboard bench for pingpong_dsp_stage: stimulus pushes expected writes,
// a negedge monitor pops and compares every presented write.
module tb_pingpong_dsp_stage;
  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 8;
  localparam int FRAME_LEN = 128;
  localparam int SHIFT     = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              readyb_in = 1'b0;
  logic [ADDR_W-1:0] addrb_in;
  logic [DATA_W-1:0] doutb_in = '0;
  logic              finishb_in;
  logic              readya_out = 1'b0;
  logic [ADDR_W-1:0] addra_out;
  logic [DATA_W-1:0] dina_out;
  logic              wea_out;
  logic              finisha_out;
  logic [7:0]        gain = '0;
  logic [7:0]        offset = '0;
  logic              busy;
  logic [15:0]       frame_cnt;

  pingpong_dsp_stage #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .readyb_in(readyb_in), .addrb_in(addrb_in), .doutb_in(doutb_in),
    .finishb_in(finishb_in),
    .readya_out(readya_out), .addra_out(addra_out), .dina_out(dina_out),
    .wea_out(wea_out), .finisha_out(finisha_out),
    .gain(gain), .offset(offset), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          start_cycs[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          fin_cnt = 0;
  int          fin_cyc = 0;
  int          exp_frames = 0;
  logic        busy_prev = 1'b0;
  logic [7:0]  in_ram  [FRAME_LEN];
  logic [7:0]  out_ram [FRAME_LEN];

  // Synchronous-read input RAM model.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    doutb_in <= in_ram[addrb_in];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] d, input logic [7:0] g,
                                       input logic [7:0] o);
    int v;
    v = (int'(d) * int'(g)) >>> SHIFT;
    v = v + int'(o);
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  task automatic push_frame(input logic [7:0] g, input logic [7:0] o);
    wr_t w;
    for (int i = 0; i < FRAME_LEN; i++) begin
      w.addr = ADDR_W'(i);
      w.data = model(in_ram[i], g, o);
      exp_q.push_back(w);
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    wr_t e;
    if (wea_out) begin
      wr_cnt++;
      out_ram[addra_out] = dina_out;
      chk("wea_inside_frame", int'(busy), 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", int'(addra_out), int'(e.addr));
        chk("wr_data", int'(dina_out), int'(e.data));
      end
    end
    if (finishb_in || finisha_out) begin
      fin_cnt++;
      fin_cyc = cyc;
      chk("finish_coincide", int'(finishb_in), int'(finisha_out));
    end
    if (busy && !busy_prev) start_cycs.push_back(cyc);
    busy_prev = busy;
  end

  task automatic wait_busy(input logic lvl, input string name);
    int n;
    n = 0;
    while (busy !== lvl && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(busy === lvl), 1);
  endtask

  // Start a frame, drop readyb_in once address drop_addr is issued, check timing.
  task automatic run_frame(input logic [7:0] g, input logic [7:0] o, input int drop_addr);
    int s, w0, f0, n;
    push_frame(g, o);
    gain = g;
    offset = o;
    w0 = wr_cnt;
    f0 = fin_cnt;
    readya_out = 1'b1;
    readyb_in  = 1'b1;
    wait_busy(1'b1, "frame_start");
    s = cyc;
    n = 0;
    while (!(busy && int'(addrb_in) == drop_addr) && n < 300) begin
      @(negedge clk);
      n++;
    end
    readyb_in = 1'b0;
    wait_busy(1'b0, "frame_end");
    // First READ cycle is s; the IDLE decision cycle is s-1, finish lands 131 later.
    chk("finish_latency", fin_cyc - (s - 1), FRAME_LEN + 3);
    chk("write_count", wr_cnt - w0, FRAME_LEN);
    chk("finish_pulses", fin_cnt - f0, 1);
    exp_frames++;
    chk("frame_cnt", int'(frame_cnt), exp_frames);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int w0, f0, idle_bad, n;
    for (int i = 0; i < FRAME_LEN; i++) begin
      in_ram[i]  = 8'(i);
      out_ram[i] = 8'hxx;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_wea", int'(wea_out), 0);
    chk("rst_finish", int'(finishb_in | finisha_out), 0);
    chk("rst_addrb", int'(addrb_in), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp through unity gain (16 >> 4).
    run_frame(8'd16, 8'd0, 0);
    chk("ramp_out0", int'(out_ram[0]), 0);
    chk("ramp_out64", int'(out_ram[64]), 64);
    chk("ramp_out127", int'(out_ram[127]), 127);

    // Full-scale input saturates.
    for (int i = 0; i < FRAME_LEN; i++) in_ram[i] = 8'hFF;
    run_frame(8'd255, 8'd10, 0);
    chk("sat_out0", int'(out_ram[0]), 255);
    chk("sat_out127", int'(out_ram[127]), 255);

    // Output bank busy: nothing may start; then gain=0 gives offset everywhere.
    gain = 8'd0;
    offset = 8'd77;
    readyb_in = 1'b1;
    readya_out = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy || wea_out || addrb_in != '0) idle_bad++;
    end
    chk("idle_hold", idle_bad, 0);
    push_frame(8'd0, 8'd77);
    w0 = wr_cnt;
    f0 = fin_cnt;
    readya_out = 1'b1;
    @(negedge clk);
    chk("start_next_cycle", int'(busy), 1);
    readyb_in = 1'b0;
    wait_busy(1'b0, "gain0_end");
    exp_frames++;
    chk("gain0_writes", wr_cnt - w0, FRAME_LEN);
    chk("gain0_finish", fin_cnt - f0, 1);
    chk("gain0_out10", int'(out_ram[10]), 77);

    // readyb_in dropped mid-frame at address 60: frame still completes.
    for (int i = 0; i < FRAME_LEN; i++) in_ram[i] = 8'(i * 3) ^ 8'h5A;
    run_frame(8'd37, 8'd9, 60);
    chk("mix_out0", int'(out_ram[0]), 217);
    chk("mix_out1", int'(out_ram[1]), 214);

    // Reset at write address 40 aborts the frame.
    push_frame(8'd16, 8'd1);
    gain = 8'd16;
    offset = 8'd1;
    readyb_in = 1'b1;
    readya_out = 1'b1;
    f0 = fin_cnt;
    n = 0;
    while (!(wea_out && addra_out == 7'd40) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wr40", int'(wea_out && addra_out == 7'd40), 1);
    #1;
    rst_n = 1'b0;
    readyb_in = 1'b0;
    readya_out = 1'b0;
    #1;
    chk("abort_wea", int'(wea_out), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_addra", int'(addra_out), 0);
    chk("abort_dina", int'(dina_out), 0);
    chk("abort_frame_cnt", int'(frame_cnt), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("abort_no_finish", fin_cnt - f0, 0);
    rst_n = 1'b1;
    exp_frames = 0;
    @(negedge clk);
    for (int i = 0; i < FRAME_LEN; i++) in_ram[i] = 8'(i);
    run_frame(8'd16, 8'd0, 0);

    // Three back-to-back frames; gain changes during frame 2.
    start_cycs.delete();
    w0 = wr_cnt;
    push_frame(8'd20, 8'd3);
    push_frame(8'd20, 8'd3);
    gain = 8'd20;
    offset = 8'd3;
    readyb_in = 1'b1;
    readya_out = 1'b1;
    n = 0;
    while (start_cycs.size() < 2 && n < 600) begin
      @(negedge clk);
      n++;
    end
    repeat (60) @(negedge clk);
    gain = 8'd200;
    offset = 8'd50;
    push_frame(8'd200, 8'd50);
    n = 0;
    while (start_cycs.size() < 3 && n < 600) begin
      @(negedge clk);
      n++;
    end
    readyb_in = 1'b0;
    chk("b2b_starts", start_cycs.size(), 3);
    if (start_cycs.size() >= 3) begin
      chk("b2b_gap1", start_cycs[1] - start_cycs[0], FRAME_LEN + 5);
      chk("b2b_gap2", start_cycs[2] - start_cycs[1], FRAME_LEN + 5);
    end
    wait_busy(1'b0, "b2b_end");
    exp_frames += 3;
    chk("b2b_frame_cnt", int'(frame_cnt), exp_frames);
    chk("b2b_writes", wr_cnt - w0, 3 * FRAME_LEN);
    chk("b2b_queue", exp_q.size(), 0);
    chk("b2b_out10", int'(out_ram[10]), 175);
    chk("b2b_out127", int'(out_ram[127]), 255);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pingpong_dsp_stage.md
Name: pingpong_dsp_stage

Overview:
- Processing stage between the MOSI ping-pong RAM read port and the MISO ping-pong RAM write port.
- Drains one full frame of received bytes and applies gain, shift, offset and saturation to each byte.
- Writes the results into the free output bank, then releases both banks with single-cycle finish pulses.
- Sets the per-frame throughput seen by the SPI side's DRDY.

Parameters:
- ADDR_W, 7, RAM address width.
- DATA_W, 8, sample width, unsigned.
- FRAME_LEN, 128, bytes per frame; must be ≤ 2^ADDR_W.
- SHIFT, 4, right shift applied to the gain product.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- readyb_in  input  1  input bank full and readable
- addrb_in  output  ADDR_W  input RAM read address
- doutb_in  input  DATA_W  input RAM read data, valid 1 cycle after address
- finishb_in  output  1  1-cycle pulse: input bank consumed
- readya_out  input  1  output bank free for writing
- addra_out  output  ADDR_W  output RAM write address
- dina_out  output  DATA_W  output RAM write data
- wea_out  output  1  output RAM write enable
- finisha_out  output  1  1-cycle pulse: output bank written
- gain  input  8  multiplier, unsigned, latched at frame start
- offset  input  8  adder, unsigned, latched at frame start
- busy  output  1  high whenever state ≠ IDLE
- frame_cnt  output  16  completed frames, wraps 0xFFFF→0

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - state = IDLE.
  - All outputs 0: addrb_in, addra_out, dina_out, wea_out, finishb_in, finisha_out, busy, frame_cnt.
  - Internal latches and pipeline valid bits cleared.
- FSM states: IDLE, READ, DRAIN, DONE, SETTLE.
- IDLE:
  - If readyb_in && readya_out, latch gain/offset, set rd_addr = 0, go to READ.
  - Otherwise stay in IDLE.
- READ:
  - Each cycle drive addrb_in = rd_addr and mark stage-1 valid.
  - rd_addr increments each cycle.
  - After issuing address FRAME_LEN-1, go to DRAIN.
- Pipeline:
  - Cycle t: address issued.
  - t+1: doutb_in sampled, product computed.
  - t+2: wea_out = 1, addra_out = address from t, dina_out = result.
  - Result = min(255, ((doutb × gain_l) >> SHIFT) + offset_l).
  - Product is 16 bits and the sum 9 bits before saturation; no wrap allowed.
- DRAIN: stays 2 cycles until the last write (address FRAME_LEN-1) has been presented, then goes to DONE.
- DONE, 1 cycle:
  - finishb_in = finisha_out = 1, simultaneously.
  - frame_cnt += 1.
  - wea_out = 0.
  - Go to SETTLE.
- SETTLE: 1 cycle so the RAM ready flags can swap banks, then go to IDLE.
- Timing:
  - Frame start to finish pulse = FRAME_LEN + 3 cycles (READ FRAME_LEN, DRAIN 2, DONE 1).
  - Minimum frame period = FRAME_LEN + 5 cycles.
- Ready sampling:
  - readyb_in and readya_out are sampled only in IDLE.
  - Deassertion mid-frame is ignored; a started frame always completes.
- gain/offset changes mid-frame have no effect until the next frame.
- Write ordering:
  - wea_out is high for exactly FRAME_LEN cycles per frame, contiguous, addresses 0..FRAME_LEN-1 in order.
  - wea_out is never high outside READ/DRAIN.
- Reset mid-frame aborts:
  - No finish pulses.
  - frame_cnt is not incremented beyond its reset value.
  - The partially written bank is not released.
- gain = 0 gives output = offset for every byte.
- Saturation applies at both the product stage (via the shift) and the final add.

Test Plan:
- Reset, then readyb_in = readya_out = 1, ramp input 0..127, gain = 16, offset = 0, SHIFT = 4 → output RAM holds 0..127; finish pulses coincide at cycle 131 after start; frame_cnt = 1.
- Input all 0xFF, gain = 255, offset = 10 → every dina_out = 255 (saturated); wea_out high for exactly 128 cycles.
- readya_out = 0 with readyb_in = 1 for 50 cycles → busy = 0, no address or wea activity; raise readya_out → frame starts the next cycle.
- Deassert readyb_in at address 60 → frame completes all 128 writes and pulses both finishes once.
- Assert rst_n = 0 at write address 40 → all outputs 0 immediately, no finish pulse, frame_cnt = 0; release reset and the next frame runs normally.
- Three back-to-back frames with ready held high → frame starts spaced 133 cycles apart; frame_cnt = 3; gain changed mid-frame 2 only takes effect in frame 3.
